// File: rtl/dino_pkg.sv
// Shared constants for the dino game controller: parameter defaults and
// the encoding of the controller's three game states.
package dino_pkg;

  localparam int TICK_DIV_DEF   = 4;
  localparam int JUMP_TICKS_DEF = 3;
  localparam int SCORE_W_DEF    = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

endpackage

// File: rtl/dino_game_ctrl_if.sv
// Bundle of the player buttons, the obstacle_generator link and the game
// status outputs. The controller uses the master side, its environment the
// slave side.
interface dino_game_ctrl_if import dino_pkg::*; #(
  parameter int SCORE_W = SCORE_W_DEF
);

  logic               start;
  logic               jump;
  logic [7:0]         ledLine;
  logic               obs_step;
  logic               obs_clear;
  logic               dino_up;
  logic               collision;
  logic               game_over;
  logic [SCORE_W-1:0] score;

  modport master (
    input  start, jump, ledLine,
    output obs_step, obs_clear, dino_up, collision, game_over, score
  );

  modport slave (
    output start, jump, ledLine,
    input  obs_step, obs_clear, dino_up, collision, game_over, score
  );

endinterface

// File: rtl/dino_game_ctrl_rise_det.sv
// Rising-edge detector: remembers last cycle's level in a flop and flags a
// cycle where the input is high but was low one clock earlier.
module rise_det (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev;

  // Capture the previous level of the button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= in;
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino game controller: paces the obstacle stream, handles the jump, detects
// a hit on the dino column and keeps score. Every output comes from a flop.
module dino_game_ctrl import dino_pkg::*; #(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int JUMP_TICKS = JUMP_TICKS_DEF,
  parameter int SCORE_W    = SCORE_W_DEF
) (
  input logic clk,
  input logic reset,
  dino_game_ctrl_if.master bus
);

  localparam int                 TICK_W     = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0]         AIR_LOAD   = 4'(JUMP_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  logic [1:0]         state;
  logic [TICK_W-1:0]  tick_cnt;
  logic [3:0]         air_cnt;
  logic               step_q;
  logic               clear_q;
  logic               up_q;
  logic               coll_q;
  logic               over_q;
  logic [SCORE_W-1:0] score_q;

  logic start_rise;
  logic jump_rise;
  logic in_run;
  logic hit;
  logic step_due;
  logic new_game;
  logic unused_led;

  rise_det u_start_rise (
    .clk   (clk),
    .reset (reset),
    .in    (bus.start),
    .pulse (start_rise)
  );

  rise_det u_jump_rise (
    .clk   (clk),
    .reset (reset),
    .in    (bus.jump),
    .pulse (jump_rise)
  );

  // A hit pre-empts everything else in the same cycle, including the step
  // that would otherwise be due, so the dying step never counts.
  assign in_run     = (state == ST_RUN);
  assign hit        = in_run & bus.ledLine[0] & ~up_q;
  assign step_due   = in_run & ~hit & (tick_cnt == TICK_LAST);
  assign new_game   = ~in_run & start_rise;
  assign unused_led = ^bus.ledLine[7:1];

  // Game state plus the sticky collision and game-over flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      coll_q <= 1'b0;
      over_q <= 1'b0;
    end else if (new_game) begin
      state  <= ST_RUN;
      coll_q <= 1'b0;
      over_q <= 1'b0;
    end else if (hit) begin
      state  <= ST_OVER;
      coll_q <= 1'b1;
      over_q <= 1'b1;
    end
  end

  // Step pacing counter, only running while a game is in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (new_game) begin
      tick_cnt <= '0;
    end else if (in_run && !hit) begin
      if (tick_cnt == TICK_LAST) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Jump: launch only from the ground, land after the air counter runs out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_q    <= 1'b0;
      air_cnt <= '0;
    end else if (new_game) begin
      up_q    <= 1'b0;
      air_cnt <= '0;
    end else if (in_run && !hit) begin
      if (up_q) begin
        if (step_due) begin
          air_cnt <= air_cnt - 4'd1;
          if (air_cnt == 4'd1) up_q <= 1'b0;
        end
      end else if (jump_rise) begin
        up_q    <= 1'b1;
        air_cnt <= AIR_LOAD;
      end
    end
  end

  // Score: one point per survived step, pinned at the maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
    end else if (new_game) begin
      score_q <= '0;
    end else if (step_due && score_q != SCORE_MAX) begin
      score_q <= score_q + SCORE_W'(1);
    end
  end

  // One-cycle strobes towards the obstacle generator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      step_q  <= step_due;
      clear_q <= new_game;
    end
  end

  assign bus.obs_step  = step_q;
  assign bus.obs_clear = clear_q;
  assign bus.dino_up   = up_q;
  assign bus.collision = coll_q;
  assign bus.game_over = over_q;
  assign bus.score     = score_q;

endmodule

// File: doc/dino_game_ctrl.md
DINO_GAME_CTRL -- requirements
Module: dino_game_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 4, clocks per game step (legal 2..256).
REQ-002 Parameter: JUMP_TICKS, default 3, game steps dino stays airborne (legal 1..15).
REQ-003 Parameter: SCORE_W, default 8, score counter width.
REQ-004 Port: clk  input  1  single system clock; all state on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: start  input  1  start/restart button level, synchronous to clk.
REQ-007 Port: jump  input  1  jump button level, synchronous to clk.
REQ-008 Port: ledLine  input  8  obstacle bitmap from obstacle_generator; bit 0 = dino column.
REQ-009 Port: obs_step  output  1  one-cycle enable advancing obstacle_generator one position.
REQ-010 Port: obs_clear  output  1  one-cycle request to clear obstacle_generator.
REQ-011 Port: dino_up  output  1  dino airborne.
REQ-012 Port: collision  output  1  sticky collision flag.
REQ-013 Port: game_over  output  1  high while in OVER state.
REQ-014 Port: score  output  SCORE_W  steps survived in the current game.

Function
REQ-015 FSM states IDLE, RUN, OVER; all outputs registered.
REQ-016 Rising edges of start and jump detected against registered previous values; levels alone have no effect.
REQ-017 start edge in IDLE or OVER -> RUN next cycle; same edge: obs_clear=1 one cycle, score=0, collision=0, dino_up=0, tick counter=0, air counter=0.
REQ-018 start edge in RUN ignored.
REQ-019 In RUN only, tick counter counts 0..TICK_DIV-1 and wraps; obs_step=1 for exactly the cycle after counter equals TICK_DIV-1, hence one pulse per TICK_DIV clocks; first pulse TICK_DIV cycles after entering RUN.
REQ-020 obs_step=0 in IDLE and OVER; tick counter holds.
REQ-021 jump edge in RUN with dino_up=0 -> dino_up=1 next cycle, air counter loaded JUMP_TICKS.
REQ-022 jump edge while dino_up=1, or outside RUN, ignored (no re-trigger, no extension).
REQ-023 Air counter decrements on each obs_step while dino_up=1; the obs_step taking it to 0 also clears dino_up on the same edge.
REQ-024 Collision condition: state RUN, ledLine[0]=1, dino_up=0 (registered value), evaluated every clock.
REQ-025 On collision condition: next edge collision=1, game_over=1, state OVER; no obs_step and no score change on that edge.
REQ-026 Collision and jump edge in same cycle: collision wins; dino_up stays 0.
REQ-027 Collision and obs_step-due in same cycle: collision wins; step suppressed, score unchanged.
REQ-028 score increments by 1 on each obs_step in RUN; saturates at all-ones, never wraps.
REQ-029 In OVER, collision, score, dino_up hold until a start edge (REQ-017).

Reset
REQ-030 reset=1 asynchronously forces IDLE, obs_step=0, obs_clear=0, dino_up=0, collision=0, game_over=0, score=0, all counters and edge-detect registers 0.
REQ-031 Reset asserted mid-game (RUN or OVER) aborts immediately; after release, block waits in IDLE for a start edge.

Structure
REQ-032 Shared package dino_pkg holds the state enumeration and default values of TICK_DIV, JUMP_TICKS, SCORE_W.
REQ-033 One sub-module rise_det (registered rising-edge detector, clk/reset/in/pulse) instantiated for start and jump.

Verification (TICK_DIV=4, JUMP_TICKS=3)
REQ-034 reset=1 then release, start=0 for 20 cycles -> all outputs 0, no obs_step.
REQ-035 start edge, ledLine=8'h00 -> obs_clear one cycle, obs_step every 4th cycle, score=10 after 10 pulses.
REQ-036 In RUN jump edge, then ledLine=8'h01 for the next 2 obs_steps -> dino_up=1 for 3 obs_steps, collision stays 0.
REQ-037 In RUN, dino_up=0, ledLine=8'h01 -> next edge collision=1, game_over=1; obs_step stops; score frozen.
REQ-038 SCORE_W=4, ledLine=8'h00, 20 obs_steps -> score=4'hF, no wrap.
REQ-039 In OVER with score=7, start edge -> obs_clear pulse, score=0, collision=0, game_over=0, RUN resumes.
